o_feature_store: RTL
====================

Name: o_feature_store

Overview:
- Write-back engine: the outbound counterpart of the input feature fetch path.
- On a decoded store command, it reads a run of 128-bit words from one of the two local feature banks (dual-port RAMs, 1-cycle read latency).
- It streams those words onto the external data bus with incrementing addresses and a valid/ready handshake.
- It sits between the feature RAM read ports and the external memory interface, and signals completion back to the control FSM.

Parameters:
DATA_BUS_WIDTH, 128, width of local RAM words and external data bus
LOCAL_ADDR_WIDTH, 8, local feature RAM address width
EXT_ADDR_WIDTH, 16, external bus word address width
CNT_WIDTH, 8, width of store word count

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-low
store_enable  input  1  one-cycle command strobe from instruction decode
src_addr  input  LOCAL_ADDR_WIDTH  first local RAM word address
dst_addr  input  EXT_ADDR_WIDTH  first external word address
store_counter  input  CNT_WIDTH  number of words to move
mem_sel  input  1  source bank: 0 = bank 0, 1 = bank 1
mem_rd_en_0  output  1  bank 0 read enable
mem_rd_addr_0  output  LOCAL_ADDR_WIDTH  bank 0 read address
mem_rd_data_0  input  DATA_BUS_WIDTH  bank 0 read data, valid one cycle after mem_rd_en_0
mem_rd_en_1  output  1  bank 1 read enable
mem_rd_addr_1  output  LOCAL_ADDR_WIDTH  bank 1 read address
mem_rd_data_1  input  DATA_BUS_WIDTH  bank 1 read data, valid one cycle after mem_rd_en_1
o_data  output  DATA_BUS_WIDTH  external write data
o_addr  output  EXT_ADDR_WIDTH  external write word address
o_wr_en  output  1  external write valid
i_wr_ready  input  1  external sink ready; a word transfers when o_wr_en && i_wr_ready
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0 immediately.
  - State goes to IDLE; buffer empties; counters clear.
  - Reset mid-transfer abandons the transfer with no done pulse.
- States:
  - IDLE: busy=0. On store_enable, latch src_addr, dst_addr, store_counter and mem_sel.
    - store_counter=0: go to FIN.
    - Otherwise: go to RUN.
  - RUN: busy=1. Issue reads and drain the buffer. Leave when all N words are transferred on the bus; go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- store_enable outside IDLE is ignored; no queueing.
- Read side:
  - Only the latched bank's rd_en may assert; the other bank's rd_en and rd_addr stay 0.
  - One read is issued per cycle while issued < N and (buffer occupancy + reads in flight) < 2.
  - The read address increments per issue and wraps modulo 2^LOCAL_ADDR_WIDTH.
  - Returned data is captured into a 2-entry FIFO on the cycle after rd_en.
- Write side:
  - o_wr_en=1 whenever the FIFO is non-empty.
  - o_data = FIFO head; o_addr = current external address.
  - o_data and o_addr hold stable while o_wr_en=1 and i_wr_ready=0.
  - On each transfer, pop the FIFO and increment o_addr, wrapping modulo 2^EXT_ADDR_WIDTH.
- Timing, with store_enable high in cycle E and i_wr_ready held high:
  - rd_en high in E+1 .. E+N.
  - o_wr_en high in E+3 .. E+2+N.
  - done in E+3+N.
  - busy high in E+1 .. E+2+N.
  - Throughput: 1 word/cycle.
- N=0: no reads, no writes, busy stays 0, done pulses in E+1.
- Backpressure of any length must not lose, duplicate or reorder words. Reads stall so the FIFO never overflows.
- A simultaneous push and pop on a full or one-entry FIFO is legal; occupancy is unchanged.

Test Plan:
- Reset: rst low mid-RUN with N=8 -> all outputs 0 within the same cycle; after release, IDLE with no done pulse.
- Basic: bank 0 preloaded with word i = i*0x11 at addresses 0x10..0x13; store_enable with src=0x10, dst=0x0200, N=4, ready=1 -> four writes at 0x0200..0x0203 in E+3..E+6 with matching data; done in E+7; bank 1 rd_en never high.
- Backpressure: N=6 from bank 1, i_wr_ready toggled 1,0,0,1,0,1,... -> exactly 6 transfers in order; o_data and o_addr stable through every stalled cycle; FIFO never exceeds 2 entries.
- Wrap: src=0xFE, dst=0xFFFF, N=4 -> local reads at 0xFE, 0xFF, 0x00, 0x01; external addresses 0xFFFF, 0x0000, 0x0001, 0x0002.
- Zero/ignore: N=0 -> done in E+1, no rd_en, no o_wr_en; a second store_enable during an N=5 RUN -> ignored, exactly 5 words written, one done pulse.

Source files
------------

// File: rtl/o_feature_store.sv
// o_feature_store: write-back engine. On a store command it reads a run of
// words from one local feature bank (1-cycle read latency), buffers them in a
// 2-entry FIFO and streams them onto the external bus with incrementing
// addresses. The completion pulse goes back to the control FSM.
//
// External handshake: o_wr_en is valid, i_wr_ready is ready. A word moves on
// every cycle where both are high; while o_wr_en is high and i_wr_ready is low,
// o_data and o_addr hold. Valid never depends on ready, so no combinational
// loop exists through the sink.
module o_feature_store #(
    parameter int DATA_BUS_WIDTH   = 128,
    parameter int LOCAL_ADDR_WIDTH = 8,
    parameter int EXT_ADDR_WIDTH   = 16,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        store_enable,
    input  logic [LOCAL_ADDR_WIDTH-1:0] src_addr,
    input  logic [EXT_ADDR_WIDTH-1:0]   dst_addr,
    input  logic [CNT_WIDTH-1:0]        store_counter,
    input  logic                        mem_sel,
    output logic                        mem_rd_en_0,
    output logic [LOCAL_ADDR_WIDTH-1:0] mem_rd_addr_0,
    input  logic [DATA_BUS_WIDTH-1:0]   mem_rd_data_0,
    output logic                        mem_rd_en_1,
    output logic [LOCAL_ADDR_WIDTH-1:0] mem_rd_addr_1,
    input  logic [DATA_BUS_WIDTH-1:0]   mem_rd_data_1,
    output logic [DATA_BUS_WIDTH-1:0]   o_data,
    output logic [EXT_ADDR_WIDTH-1:0]   o_addr,
    output logic                        o_wr_en,
    input  logic                        i_wr_ready,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;

    logic                        r_bank;
    logic [LOCAL_ADDR_WIDTH-1:0] r_rd_addr;
    logic [EXT_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [CNT_WIDTH-1:0]        r_issue_left;
    logic [CNT_WIDTH-1:0]        r_xfer_left;
    logic                        r_inflight;

    logic [DATA_BUS_WIDTH-1:0]   r_fifo [0:1];
    logic                        r_head;
    logic                        r_tail;
    logic [1:0]                  r_count;

    logic                        w_pop;
    logic [2:0]                  w_occ_after;
    logic                        w_issue;
    logic                        w_last_xfer;
    logic [DATA_BUS_WIDTH-1:0]   w_rd_data;

    // The FIFO can only be non-empty in RUN, so a pop implies RUN.
    assign w_pop       = (r_count != 2'd0) && i_wr_ready;
    // Buffered plus in-flight words after this cycle's pop; a new read is
    // allowed only if its returning word still fits in the two entries.
    // Counting the same-cycle pop is what sustains one word per cycle.
    assign w_occ_after = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == S_RUN) && (r_issue_left != '0) &&
                         (w_occ_after < 3'd2);
    assign w_last_xfer = w_pop && (r_xfer_left == CNT_WIDTH'(1));
    assign w_rd_data   = r_bank ? mem_rd_data_1 : mem_rd_data_0;

    // Only the latched bank sees a read; the other bank's port stays at zero.
    assign mem_rd_en_0   = w_issue && !r_bank;
    assign mem_rd_en_1   = w_issue && r_bank;
    assign mem_rd_addr_0 = (w_issue && !r_bank) ? r_rd_addr : '0;
    assign mem_rd_addr_1 = (w_issue && r_bank)  ? r_rd_addr : '0;

    assign o_wr_en = (r_count != 2'd0);
    assign o_data  = r_fifo[r_head];
    assign o_addr  = r_wr_addr;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_FIN);
    assign o_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: start on a command, finish on the last bus transfer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (store_enable) begin
                    w_next_state = (store_counter == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_xfer) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command latch plus read-side and write-side address/count tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank       <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_issue_left <= '0;
            r_xfer_left  <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if ((r_state == S_IDLE) && store_enable) begin
                r_bank       <= mem_sel;
                r_rd_addr    <= src_addr;
                r_wr_addr    <= dst_addr;
                r_issue_left <= store_counter;
                r_xfer_left  <= store_counter;
            end else begin
                if (w_issue) begin
                    r_rd_addr    <= r_rd_addr + LOCAL_ADDR_WIDTH'(1);
                    r_issue_left <= r_issue_left - CNT_WIDTH'(1);
                end
                if (w_pop) begin
                    r_wr_addr   <= r_wr_addr + EXT_ADDR_WIDTH'(1);
                    r_xfer_left <= r_xfer_left - CNT_WIDTH'(1);
                end
            end
        end
    end

    // 2-entry FIFO: capture read data the cycle after rd_en, pop on transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo[r_tail] <= w_rd_data;
                r_tail         <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
